fifo_wr_arbiter: RTL and testbench

- Shares the single write port of one BRAM-backed 16-bit FIFO between NUM_REQ independent producers.
- Uses round-robin arbitration with burst locking. A granted requester keeps the port until it flags its last beat, or until MAX_BURST beats have been written.
- Sits between the producer blocks and the FIFO's we/d/full pins. Everything runs in the FIFO write-clock domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: data width default,
// FSM state type, default burst cap and a modulo-N pointer increment.
package fifo_wr_arbiter_pkg;

   localparam int unsigned FIFO_DATA_WIDTH   = 16;
   localparam int unsigned DEFAULT_MAX_BURST = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Explicit wrap so non-power-of-2 counts never step past n-1.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bus of the write arbiter. master = producers + FIFO model,
// slave = the arbiter itself.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16
);
   localparam int unsigned GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_we;
   logic [DATA_WIDTH-1:0]         fifo_d;
   logic [GW-1:0]                 grant_id;
   logic                          busy;

   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_we, fifo_d, grant_id, busy
   );

   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_we, fifo_d, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority encoder: first set bit of i_req at or after
// i_ptr, wrapping at N. Shared with the read-side scheduler.
module rr_pick #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic          o_any,
   output logic [PW-1:0] o_idx
);

   logic [PW:0] w_j;

   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      w_j   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_j >= (PW+1)'(N)) begin
            w_j = w_j - (PW+1)'(N);
         end
         if (!o_any && i_req[w_j[PW-1:0]]) begin
            o_any = 1'b1;
            o_idx = w_j[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst locking that shares one FIFO write port
// between NUM_REQ producers; beats are muxed straight through to the FIFO.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST
) (
   input  logic             clk,
   input  logic             rst_n,
   fifo_wr_arbiter_if.slave bus
);

   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   state_t              r_state;
   logic                r_busy;
   logic [GW-1:0]       r_rr_ptr;
   logic [GW-1:0]       r_grant;
   logic [CW-1:0]       r_beat_cnt;

   logic                w_any;
   logic [GW-1:0]       w_idx;
   logic                w_we;
   logic                w_end;
   logic [NUM_REQ-1:0]  w_ready;
   logic [DATA_WIDTH-1:0] w_d;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req (bus.req_valid),
      .i_ptr (r_rr_ptr),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   // Write path is purely combinational off the registered owner, so an
   // asynchronous reset of r_state silences it immediately.
   always_comb begin
      w_we    = 1'b0;
      w_end   = 1'b0;
      w_ready = '0;
      w_d     = '0;
      if (r_state == ST_BURST) begin
         w_ready[r_grant] = ~bus.fifo_full;
         w_we             = bus.req_valid[r_grant] & ~bus.fifo_full;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
               w_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         w_end = w_we & (bus.req_last[r_grant] | (r_beat_cnt == CW'(MAX_BURST - 1)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant    <= w_idx;
                  r_beat_cnt <= '0;
                  r_state    <= ST_BURST;
                  r_busy     <= 1'b1;
               end
            end
            ST_BURST: begin
               if (w_we) begin
                  r_beat_cnt <= r_beat_cnt + CW'(1);
                  if (w_end) begin
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                     r_rr_ptr <= GW'(wrap_inc(32'(r_grant), NUM_REQ));
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.fifo_we   = w_we;
   assign bus.fifo_d    = w_d;
   assign bus.grant_id  = r_grant;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester beat queues drive the
// producers, expected FIFO writes are queued up front and popped on fifo_we.
module tb_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;

   logic [16:0]   src_q [NR][$];
   logic [17:0]   exp_q [$];
   int unsigned   wr_cyc [$];
   logic [NR-1:0] hold    = '0;
   logic          tb_full = 1'b0;

   logic          s_we, s_busy, s_full;
   logic [NR-1:0] s_ready;
   logic [DW-1:0] s_d;
   logic [1:0]    s_gid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drive();
      logic [NR-1:0]    v;
      logic [NR-1:0]    l;
      logic [NR*DW-1:0] d;
      logic [16:0]      h;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0 && !hold[i]) begin
            h            = src_q[i][0];
            v[i]         = 1'b1;
            l[i]         = h[16];
            d[i*DW +: DW] = h[15:0];
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.fifo_full = tb_full;
   endtask

   task automatic load(input int r, input logic [15:0] base, input int n, input bit every);
      for (int k = 0; k < n; k++)
         src_q[r].push_back({(every || k == n-1), base + 16'(k)});
   endtask

   task automatic expect_wr(input int id, input logic [15:0] base, input int n);
      for (int k = 0; k < n; k++)
         exp_q.push_back({2'(id), base + 16'(k)});
   endtask

   function automatic int unsigned src_pending();
      int unsigned s = 0;
      for (int i = 0; i < NR; i++) s += src_q[i].size();
      return s;
   endfunction

   // Sample on the falling edge, advance producers after the rising edge.
   task automatic step();
      logic [17:0]   e;
      logic [NR-1:0] acc;
      @(negedge clk);
      cyc++;
      s_we = bus.fifo_we; s_busy = bus.busy; s_full = bus.fifo_full;
      s_ready = bus.req_ready; s_d = bus.fifo_d; s_gid = bus.grant_id;
      chk("inv_we_while_full", 32'(s_we & s_full), 32'd0);
      chk("inv_ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
      chk("inv_we_implies_ready", 32'(s_we ? s_ready[s_gid] : 1'b1), 32'd1);
      if (s_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(s_d), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_data", 32'(s_d), 32'(e[15:0]));
            chk("wr_grant_id", 32'(s_gid), 32'(e[17:16]));
            wr_cyc.push_back(cyc);
         end
      end
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic drain(input string tag);
      int unsigned b = 0;
      while ((exp_q.size() > 0 || src_pending() > 0) && b < 300) begin
         step();
         b++;
      end
      chk(tag, 32'(b < 300), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      rst_n = 1'b1;
      drive();
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", 32'(bus.fifo_we), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_fifo_d", 32'(bus.fifo_d), 32'd0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single requester, three beats, first write one cycle after valid.
      wr_cyc.delete();
      base = cyc + 1;
      load(0, 16'h00A0, 3, 1'b0);
      expect_wr(0, 16'h00A0, 3);
      drive();
      step();
      chk("t1_idle_no_write", 32'(s_we), 32'd0);
      step();
      chk("t1_busy", 32'(s_busy), 32'd1);
      chk("t1_grant", 32'(s_gid), 32'd0);
      step();
      step();
      step();
      chk("t1_busy_drop", 32'(s_busy), 32'd0);
      chk("t1_no_write_after", 32'(s_we), 32'd0);
      chk("t1_nwrites", wr_cyc.size(), 32'd3);
      if (wr_cyc.size() == 3) begin
         chk("t1_lat0", wr_cyc[0], base + 1);
         chk("t1_lat1", wr_cyc[1], base + 2);
         chk("t1_lat2", wr_cyc[2], base + 3);
      end
      chk("t1_rr_ptr", 32'(dut.r_rr_ptr), 32'd1);

      // All four valid, every beat last; rr_ptr=1 so order starts at 1.
      wr_cyc.delete();
      for (int i = 0; i < NR; i++) load(i, 16'h2000 + 16'(i*16), 2, 1'b1);
      expect_wr(1, 16'h2010, 1); expect_wr(2, 16'h2020, 1);
      expect_wr(3, 16'h2030, 1); expect_wr(0, 16'h2000, 1);
      expect_wr(1, 16'h2011, 1); expect_wr(2, 16'h2021, 1);
      expect_wr(3, 16'h2031, 1); expect_wr(0, 16'h2001, 1);
      drive();
      drain("t2_drain");
      chk("t2_nwrites", wr_cyc.size(), 32'd8);
      if (wr_cyc.size() == 8)
         for (int k = 1; k < 8; k++) chk("t2_spacing", wr_cyc[k] - wr_cyc[k-1], 32'd2);

      // Req 1 streams 20 beats (last only on the 20th); req 2 waits.
      wr_cyc.delete();
      load(1, 16'h3100, 20, 1'b0);
      load(2, 16'h3200, 3, 1'b0);
      expect_wr(1, 16'h3100, 8);
      expect_wr(2, 16'h3200, 3);
      expect_wr(1, 16'h3108, 8);
      expect_wr(1, 16'h3110, 4);
      drive();
      drain("t3_drain");
      chk("t3_nwrites", wr_cyc.size(), 32'd23);
      if (wr_cyc.size() == 23) begin
         chk("t3_burst_contig", wr_cyc[7] - wr_cyc[0], 32'd7);
         chk("t3_trunc_gap", wr_cyc[8] - wr_cyc[7], 32'd2);
         chk("t3_regrant_gap", wr_cyc[11] - wr_cyc[10], 32'd2);
         chk("t3_second_trunc_gap", wr_cyc[19] - wr_cyc[18], 32'd2);
      end

      // FIFO full for three cycles after the second beat.
      load(2, 16'h4200, 4, 1'b0);
      expect_wr(2, 16'h4200, 4);
      drive();
      step();
      step();
      step();
      tb_full = 1'b1;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_full_no_we", 32'(s_we), 32'd0);
         chk("t4_full_no_ready", 32'(s_ready), 32'd0);
         chk("t4_full_busy", 32'(s_busy), 32'd1);
      end
      chk("t4_beat_cnt_hold", 32'(dut.r_beat_cnt), 32'd2);
      tb_full = 1'b0;
      drive();
      drain("t4_drain");

      // Owner valid gap of two cycles; req 0 waits and must not be served early.
      load(3, 16'h5300, 4, 1'b0);
      load(0, 16'h5000, 2, 1'b0);
      expect_wr(3, 16'h5300, 4);
      expect_wr(0, 16'h5000, 2);
      drive();
      step();
      step();
      step();
      hold[3] = 1'b1;
      drive();
      for (int k = 0; k < 2; k++) begin
         step();
         chk("t5_gap_no_we", 32'(s_we), 32'd0);
         chk("t5_gap_busy", 32'(s_busy), 32'd1);
         chk("t5_gap_grant", 32'(s_gid), 32'd3);
         chk("t5_gap_ready", 32'(s_ready), 32'b1000);
      end
      hold[3] = 1'b0;
      drive();
      drain("t5_drain");

      // Asynchronous reset mid-burst, then the pointer must restart at 0.
      load(1, 16'h6100, 6, 1'b0);
      expect_wr(1, 16'h6100, 2);
      drive();
      step();
      step();
      step();
      chk("t6_pre_we", 32'(bus.fifo_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_we", 32'(bus.fifo_we), 32'd0);
      chk("t6_async_ready", 32'(bus.req_ready), 32'd0);
      chk("t6_async_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < NR; i++) src_q[i].delete();
      exp_q.delete();
      hold = '0;
      drive();
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_grant_id", 32'(bus.grant_id), 32'd0);
      rst_n = 1'b1;
      load(0, 16'h7000, 2, 1'b0);
      load(2, 16'h7200, 2, 1'b0);
      expect_wr(0, 16'h7000, 2);
      expect_wr(2, 16'h7200, 2);
      drive();
      drain("t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
